// File: rtl/adder_50_rr_sched_if.sv
// Request/response bundle between compute engines and the shared 50-bit adder scheduler.
// The master side drives requests; the slave side (the scheduler) grants and returns results.
interface adder_50_rr_sched_if #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
);
   logic                 en;
   logic [N_REQ-1:0]     req_valid;
   logic [N_REQ*50-1:0]  req_a;
   logic [N_REQ*50-1:0]  req_b;
   logic [N_REQ-1:0]     req_ready;
   logic                 rsp_valid;
   logic [ID_W-1:0]      rsp_id;
   logic [49:0]          rsp_data;
   logic                 idle;

   modport master (
      output en, req_valid, req_a, req_b,
      input  req_ready, rsp_valid, rsp_id, rsp_data, idle
   );

   modport slave (
      input  en, req_valid, req_a, req_b,
      output req_ready, rsp_valid, rsp_id, rsp_data, idle
   );
endinterface

// File: rtl/adder_50_rr_sched.sv
// Round-robin scheduler sharing one registered 50-bit adder between N_REQ requesters.
// Pipeline: accept edge -> operand regs (s1) -> adder output reg (s2) -> response bus.
module adder_50_rr_sched #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input logic                 clk,
   input logic                 rst_n,
   adder_50_rr_sched_if.slave  bus
);

   logic [ID_W-1:0] ptr_q, ptr_d;
   logic            s1_vld_q, s1_vld_d;
   logic [ID_W-1:0] s1_id_q, s1_id_d;
   logic            s2_vld_q;
   logic [ID_W-1:0] s2_id_q;
   logic [49:0]     op_a_q, op_a_d;
   logic [49:0]     op_b_q, op_b_d;
   logic [49:0]     sum_q;

   logic            accept;
   logic [ID_W-1:0] grant_id;
   int              idx;

   // Arbitration: first valid requester scanning from ptr, wrapping modulo N_REQ.
   always_comb begin
      bus.req_ready = '0;
      accept        = 1'b0;
      grant_id      = '0;
      idx           = 0;
      if (bus.en) begin
         for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!accept && bus.req_valid[idx]) begin
               accept   = 1'b1;
               grant_id = ID_W'(idx);
            end
         end
      end
      // Grant implies valid, so a grant is always an accept at the next edge.
      if (accept) begin
         bus.req_ready[grant_id] = 1'b1;
      end
   end

   // Next-state for pointer and issue stage.
   always_comb begin
      ptr_d    = ptr_q;
      s1_vld_d = accept;
      s1_id_d  = s1_id_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      if (accept) begin
         ptr_d   = (int'(grant_id) == N_REQ - 1) ? '0 : ID_W'(int'(grant_id) + 1);
         s1_id_d = grant_id;
         op_a_d  = bus.req_a[int'(grant_id)*50 +: 50];
         op_b_d  = bus.req_b[int'(grant_id)*50 +: 50];
      end
   end

   // Pointer, operand staging and id/valid tag pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q    <= '0;
         s1_vld_q <= 1'b0;
         s1_id_q  <= '0;
         s2_vld_q <= 1'b0;
         s2_id_q  <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
      end else begin
         ptr_q    <= ptr_d;
         s1_vld_q <= s1_vld_d;
         s1_id_q  <= s1_id_d;
         s2_vld_q <= s1_vld_q;
         s2_id_q  <= s1_id_q;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
      end
   end

   // Adder output register, unreset like the DSP primitive; carry out wraps away.
   always_ff @(posedge clk) begin
      sum_q <= op_a_q + op_b_q;
   end

   // Response bus; data gated so stale sums never leak out.
   always_comb begin
      bus.rsp_valid = s2_vld_q;
      bus.rsp_id    = s2_id_q;
      bus.rsp_data  = s2_vld_q ? sum_q : '0;
      bus.idle      = ~s1_vld_q & ~s2_vld_q & ~|bus.req_valid;
   end

endmodule

// File: tb/tb_adder_50_rr_sched.sv
// Directed bench for adder_50_rr_sched: table of single-requester ops plus
// hand-written sequences for round-robin, enable stall and mid-op reset.
module tb_adder_50_rr_sched;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   adder_50_rr_sched_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

   adder_50_rr_sched #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [49:0] a;
      logic [49:0] b;
      logic [49:0] sum;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if ($isunknown(act) || act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      bus.en        = 1'b1;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      clear_inputs();

      vecs[0] = '{id: 2, a: 50'd5, b: 50'd7, sum: 50'd12};
      vecs[1] = '{id: 0, a: 50'h3_FFFF_FFFF_FFFF, b: 50'd1, sum: 50'd0};
      vecs[2] = '{id: 1, a: 50'h2_0000_0000_0000, b: 50'h2_0000_0000_0000, sum: 50'd0};
      vecs[3] = '{id: 3, a: 50'd123456789, b: 50'd987654321, sum: 50'd1111111110};
      vecs[4] = '{id: 0, a: 50'h2_AAAA_AAAA_AAAA, b: 50'h1_5555_5555_5555,
                  sum: 50'h3_FFFF_FFFF_FFFF};

      // Reset state
      #12;
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_idle", 64'(bus.idle), 64'd1);
      rst_n = 1'b1;
      tick();
      chk("idle_rsp_id", 64'(bus.rsp_id), 64'd0);
      chk("idle_rsp_data", 64'(bus.rsp_data), 64'd0);
      chk("idle_idle", 64'(bus.idle), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midreset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("midreset_rsp_data", 64'(bus.rsp_data), 64'd0);
      rst_n = 1'b1;
      tick();

      // Table: one requester at a time, full two-edge latency each
      for (int v = 0; v < 5; v++) begin
         bus.req_valid = '0;
         bus.req_valid[vecs[v].id] = 1'b1;
         bus.req_a[vecs[v].id*50 +: 50] = vecs[v].a;
         bus.req_b[vecs[v].id*50 +: 50] = vecs[v].b;
         #1;
         chk($sformatf("vec%0d_ready", v), 64'(bus.req_ready), 64'(1 << vecs[v].id));
         chk($sformatf("vec%0d_idle_busy", v), 64'(bus.idle), 64'd0);
         tick();
         clear_inputs();
         #1;
         chk($sformatf("vec%0d_rsp_early", v), 64'(bus.rsp_valid), 64'd0);
         tick();
         chk($sformatf("vec%0d_rsp_valid", v), 64'(bus.rsp_valid), 64'd1);
         chk($sformatf("vec%0d_rsp_id", v), 64'(bus.rsp_id), 64'(vecs[v].id));
         chk($sformatf("vec%0d_rsp_data", v), 64'(bus.rsp_data), 64'(vecs[v].sum));
         tick();
         chk($sformatf("vec%0d_rsp_pulse", v), 64'(bus.rsp_valid), 64'd0);
         chk($sformatf("vec%0d_idle_after", v), 64'(bus.idle), 64'd1);
      end

      // Pointer after granting requester 2 alone points at 3
      do_reset();
      bus.req_valid = 4'b0100;
      bus.req_a[2*50 +: 50] = 50'd5;
      bus.req_b[2*50 +: 50] = 50'd7;
      tick();
      bus.req_valid = 4'b1111;
      #1;
      chk("ptr_after_2", 64'(bus.req_ready), 64'b1000);
      clear_inputs();
      tick();
      tick();
      tick();

      // Round-robin with all requesters valid from reset
      do_reset();
      bus.req_valid = 4'b1111;
      for (int i = 0; i < N_REQ; i++) begin
         bus.req_a[i*50 +: 50] = 50'(i);
         bus.req_b[i*50 +: 50] = 50'd100;
      end
      for (int c = 0; c < 10; c++) begin
         if (c == 8) bus.req_valid = '0;
         #1;
         if (c < 8) chk($sformatf("rr%0d_ready", c), 64'(bus.req_ready), 64'(1 << (c % 4)));
         if (c >= 2) begin
            chk($sformatf("rr%0d_rsp_valid", c), 64'(bus.rsp_valid), 64'd1);
            chk($sformatf("rr%0d_rsp_id", c), 64'(bus.rsp_id), 64'((c - 2) % 4));
            chk($sformatf("rr%0d_rsp_data", c), 64'(bus.rsp_data), 64'(100 + (c - 2) % 4));
         end
         tick();
      end
      chk("rr_end_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rr_end_idle", 64'(bus.idle), 64'd1);

      // Enable stall with ops in flight and ptr = 2
      do_reset();
      clear_inputs();
      bus.req_a[0*50 +: 50] = 50'd10;
      bus.req_b[0*50 +: 50] = 50'd1;
      bus.req_a[1*50 +: 50] = 50'd20;
      bus.req_b[1*50 +: 50] = 50'd2;
      bus.req_a[3*50 +: 50] = 50'd30;
      bus.req_b[3*50 +: 50] = 50'd3;
      bus.req_valid = 4'b0001;
      tick();
      bus.req_valid = 4'b0010;
      tick();
      bus.en = 1'b0;
      bus.req_valid = 4'b1010;
      #1;
      chk("en0_ready_a", 64'(bus.req_ready), 64'd0);
      chk("en0_rsp0_valid", 64'(bus.rsp_valid), 64'd1);
      chk("en0_rsp0_data", 64'({bus.rsp_id, bus.rsp_data}), 64'({2'd0, 50'd11}));
      tick();
      chk("en0_ready_b", 64'(bus.req_ready), 64'd0);
      chk("en0_rsp1_valid", 64'(bus.rsp_valid), 64'd1);
      chk("en0_rsp1_data", 64'({bus.rsp_id, bus.rsp_data}), 64'({2'd1, 50'd22}));
      tick();
      chk("en0_ready_c", 64'(bus.req_ready), 64'd0);
      chk("en0_drained", 64'(bus.rsp_valid), 64'd0);
      bus.en = 1'b1;
      #1;
      chk("en1_first", 64'(bus.req_ready), 64'b1000);
      tick();
      chk("en1_second", 64'(bus.req_ready), 64'b0010);
      tick();
      bus.req_valid = '0;
      chk("en1_rsp3", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_data}), 64'({1'b1, 2'd3, 50'd33}));
      tick();
      chk("en1_rsp1", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_data}), 64'({1'b1, 2'd1, 50'd22}));
      tick();

      // Reset one edge after an accept drops the op
      do_reset();
      clear_inputs();
      bus.req_valid = 4'b0100;
      bus.req_a[2*50 +: 50] = 50'd5;
      bus.req_b[2*50 +: 50] = 50'd7;
      tick();
      bus.req_valid = '0;
      rst_n = 1'b0;
      #1;
      chk("rstop_rsp_during", 64'(bus.rsp_valid), 64'd0);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("rstop_no_rsp%0d", c), 64'(bus.rsp_valid), 64'd0);
      end
      bus.req_valid = 4'b1111;
      bus.req_a[0*50 +: 50] = 50'd40;
      bus.req_b[0*50 +: 50] = 50'd2;
      #1;
      chk("rstop_ptr0", 64'(bus.req_ready), 64'b0001);
      tick();
      bus.req_valid = '0;
      tick();
      chk("rstop_rsp", 64'({bus.rsp_valid, bus.rsp_id, bus.rsp_data}), 64'({1'b1, 2'd0, 50'd42}));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
